// File: rtl/irq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_gen_pkg
// Description : Shared types, line index constants and the line-to-cause-id
//               mapping for the interrupt stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_gen_pkg;

  // Command opcode carried on cmd_mode_i
  typedef enum logic [1:0] {
    LEVEL = 2'd0,
    PULSE = 2'd1,
    CLEAR = 2'd2
  } irq_mode_e;

  // Per-line sequencing state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ASSERT = 2'd2
  } line_state_e;

  // Line indices as seen on cmd_line_i
  localparam int unsigned LineSw    = 0;
  localparam int unsigned LineTimer = 1;
  localparam int unsigned LineExt   = 2;
  localparam int unsigned LineNm    = 3;
  localparam int unsigned LineFast0 = 4;

  // Cause id that the core reports on irq_ack_id_i for a given line
  function automatic logic [4:0] line_to_id(input int unsigned line);
    logic [4:0] id;
    case (line)
      LineSw:    id = 5'd3;
      LineTimer: id = 5'd7;
      LineExt:   id = 5'd11;
      LineNm:    id = 5'd31;
      default:   id = 5'(16 + line - LineFast0);
    endcase
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_line_fsm.sv
`default_nettype none
// ============================================================================
// Module      : irq_line_fsm
// Description : One interrupt line: delay countdown, pulse-width or level hold,
//               ack-based release for level mode, and a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_line_fsm
  import irq_gen_pkg::*;
#(
  parameter int         DelayW  = 16,
  parameter int         WidthW  = 8,
  parameter logic [4:0] CauseId = 5'd0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,     // accepted LEVEL/PULSE for this line
  input  logic              level_i,     // 1: LEVEL, 0: PULSE (valid with start_i)
  input  logic              clear_i,     // accepted CLEAR for this line
  input  logic [DelayW-1:0] delay_i,
  input  logic [WidthW-1:0] width_i,
  input  logic              ack_i,
  input  logic [4:0]        ack_id_i,
  output logic              idle_o,      // current state is IDLE
  output logic              active_d_o,  // next state is not IDLE
  output logic              irq_o
);

  line_state_e       state_q, state_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic [WidthW-1:0] width_q, width_d;
  logic              level_q, level_d;
  logic              irq_q,   irq_d;

  // Next-state logic: countdowns saturate at zero, CLEAR overrides everything
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    width_d = width_q;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WAIT;
          delay_d = delay_i;
          // A zero width still produces a single-cycle pulse
          width_d = (width_i == '0) ? WidthW'(1) : width_i;
          level_d = level_i;
        end
      end
      WAIT: begin
        if (delay_q == '0) begin
          state_d = ASSERT;
        end else begin
          delay_d = delay_q - DelayW'(1);
        end
      end
      ASSERT: begin
        if (level_q) begin
          if (ack_i && (ack_id_i == CauseId)) begin
            state_d = IDLE;
          end
        end else if (width_q <= WidthW'(1)) begin
          state_d = IDLE;
        end else begin
          width_d = width_q - WidthW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      delay_d = '0;
      width_d = '0;
    end
    irq_d = (state_d == ASSERT);
  end

  // State, counters and the output flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      delay_q <= '0;
      width_q <= '0;
      level_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      width_q <= width_d;
      level_q <= level_d;
      irq_q   <= irq_d;
    end
  end

  assign idle_o     = (state_q == IDLE);
  assign active_d_o = (state_d != IDLE);
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: rtl/irq_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : irq_stim_gen
// Description : Cycle-accurate interrupt stimulus generator. Decodes commands
//               onto per-line sequencers and packs their registered outputs
//               onto the core interrupt inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_stim_gen
  import irq_gen_pkg::*;
#(
  parameter  int NumFastIrqs = 15,
  parameter  int DelayW      = 16,
  parameter  int WidthW      = 8,
  localparam int NumLines    = NumFastIrqs + 4,
  localparam int LineW       = $clog2(NumLines)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [LineW-1:0]       cmd_line_i,
  input  logic [1:0]             cmd_mode_i,   // irq_mode_e encoding
  input  logic [DelayW-1:0]      cmd_delay_i,
  input  logic [WidthW-1:0]      cmd_width_i,
  input  logic                   irq_ack_i,
  input  logic [4:0]             irq_ack_id_i,
  output logic                   irq_software_o,
  output logic                   irq_timer_o,
  output logic                   irq_external_o,
  output logic [NumFastIrqs-1:0] irq_fast_o,
  output logic                   irq_nm_o,
  output logic                   busy_o
);

  logic [NumLines-1:0] line_idle;
  logic [NumLines-1:0] line_active_d;
  logic [NumLines-1:0] line_irq;
  logic [NumLines-1:0] line_start;
  logic [NumLines-1:0] line_clear;
  logic                busy_q, busy_d;

  // Command decode: ready only for an in-range line that is IDLE or on CLEAR
  always_comb begin
    cmd_ready_o = 1'b0;
    line_start  = '0;
    line_clear  = '0;
    for (int i = 0; i < NumLines; i++) begin
      if (cmd_line_i == LineW'(i)) begin
        cmd_ready_o = line_idle[i] | (cmd_mode_i == CLEAR);
      end
    end
    for (int i = 0; i < NumLines; i++) begin
      if (cmd_valid_i && cmd_ready_o && (cmd_line_i == LineW'(i))) begin
        line_start[i] = (cmd_mode_i == LEVEL) || (cmd_mode_i == PULSE);
        line_clear[i] = (cmd_mode_i == CLEAR);
      end
    end
    busy_d = |line_active_d;
  end

  for (genvar g = 0; g < NumLines; g++) begin : g_line
    irq_line_fsm #(
      .DelayW  (DelayW),
      .WidthW  (WidthW),
      .CauseId (line_to_id(g))
    ) u_line (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (line_start[g]),
      .level_i    (cmd_mode_i == LEVEL),
      .clear_i    (line_clear[g]),
      .delay_i    (cmd_delay_i),
      .width_i    (cmd_width_i),
      .ack_i      (irq_ack_i),
      .ack_id_i   (irq_ack_id_i),
      .idle_o     (line_idle[g]),
      .active_d_o (line_active_d[g]),
      .irq_o      (line_irq[g])
    );
  end

  // Registered busy flag tracks the lines' next states so it aligns with them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign irq_software_o = line_irq[LineSw];
  assign irq_timer_o    = line_irq[LineTimer];
  assign irq_external_o = line_irq[LineExt];
  assign irq_nm_o       = line_irq[LineNm];
  assign irq_fast_o     = line_irq[NumLines-1:LineFast0];

endmodule
`default_nettype wire

// File: tb/tb_irq_stim_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_irq_stim_gen
// Description : Self-checking bench for irq_stim_gen with a timestamp-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_stim_gen;

  localparam int NF = 15;
  localparam int NL = NF + 4;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam logic [1:0] M_LEVEL = 2'd0;
  localparam logic [1:0] M_PULSE = 2'd1;
  localparam logic [1:0] M_CLEAR = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [4:0]    cmd_line_i = '0;
  logic [1:0]    cmd_mode_i = '0;
  logic [DW-1:0] cmd_delay_i = '0;
  logic [WW-1:0] cmd_width_i = '0;
  logic          irq_ack_i = 1'b0;
  logic [4:0]    irq_ack_id_i = '0;
  logic          irq_software_o, irq_timer_o, irq_external_o, irq_nm_o, busy_o;
  logic [NF-1:0] irq_fast_o;
  logic [NL-1:0] dut_vec;

  irq_stim_gen #(.NumFastIrqs(NF), .DelayW(DW), .WidthW(WW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_line_i     (cmd_line_i),
    .cmd_mode_i     (cmd_mode_i),
    .cmd_delay_i    (cmd_delay_i),
    .cmd_width_i    (cmd_width_i),
    .irq_ack_i      (irq_ack_i),
    .irq_ack_id_i   (irq_ack_id_i),
    .irq_software_o (irq_software_o),
    .irq_timer_o    (irq_timer_o),
    .irq_external_o (irq_external_o),
    .irq_fast_o     (irq_fast_o),
    .irq_nm_o       (irq_nm_o),
    .busy_o         (busy_o)
  );

  // Bit i of dut_vec is line index i
  assign dut_vec = {irq_fast_o, irq_nm_o, irq_external_o, irq_timer_o, irq_software_o};

  always #5 clk_i = ~clk_i;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: each busy line holds its on/off timestamps (edge numbers)
  bit     m_busy  [NL];
  bit     m_level [NL];
  longint m_on    [NL];
  longint m_off   [NL];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int cause_id(input int line);
    case (line)
      0:       return 3;
      1:       return 7;
      2:       return 11;
      3:       return 31;
      default: return 16 + line - 4;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) m_busy[i] = 1'b0;
  endfunction

  function automatic bit model_ready(input int line, input logic [1:0] mode);
    if (line >= NL) return 1'b0;
    return !m_busy[line] || (mode == M_CLEAR);
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NL; i++) v[i] = m_busy[i] && (cyc >= m_on[i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < NL; i++) if (m_busy[i]) b = 32'd1;
    return b;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after
  task automatic tick();
    bit     rdy_exp, acc, ak;
    int     l, w, aid;
    logic [1:0] md;
    longint d;
    #1;
    rdy_exp = model_ready(int'(cmd_line_i), cmd_mode_i);
    check_eq("cmd_ready", 32'(cmd_ready_o), 32'(rdy_exp));
    acc = cmd_valid_i && rdy_exp;
    l   = int'(cmd_line_i);
    md  = cmd_mode_i;
    d   = longint'(cmd_delay_i);
    w   = int'(cmd_width_i);
    ak  = irq_ack_i;
    aid = int'(irq_ack_id_i);
    @(posedge clk_i);
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (acc && l == i) begin
        if (md == M_CLEAR) begin
          m_busy[i] = 1'b0;
        end else if (md == M_LEVEL || md == M_PULSE) begin
          m_busy[i]  = 1'b1;
          m_level[i] = (md == M_LEVEL);
          m_on[i]    = cyc + 1 + d;
          m_off[i]   = m_on[i] + ((w == 0) ? 1 : w);
        end
      end else if (m_busy[i]) begin
        if (m_level[i]) begin
          if (ak && aid == cause_id(i) && (cyc - 1) >= m_on[i]) m_busy[i] = 1'b0;
        end else if (cyc >= m_off[i]) begin
          m_busy[i] = 1'b0;
        end
      end
    end
    #1;
    check_eq("irq_vec", 32'(dut_vec), exp_vec());
    check_eq("busy", 32'(busy_o), exp_busy());
  endtask

  task automatic drive(input bit v, input int line, input logic [1:0] m, input int d, input int w);
    cmd_valid_i = v;
    cmd_line_i  = 5'(line);
    cmd_mode_i  = m;
    cmd_delay_i = DW'(d);
    cmd_width_i = WW'(w);
  endtask

  task automatic ack(input bit a, input int id);
    irq_ack_i    = a;
    irq_ack_id_i = 5'(id);
  endtask

  task automatic idle();
    drive(1'b0, 0, M_LEVEL, 0, 0);
    ack(1'b0, 0);
  endtask

  initial begin
    int line, r;
    model_reset();

    // Reset held with a valid command pending
    drive(1'b1, 1, M_LEVEL, 0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_irq", 32'(dut_vec), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    idle();
    rst_ni = 1'b1;
    tick();
    check_eq("rel_irq", 32'(dut_vec), 32'd0);

    // LEVEL timer, delay 5: high exactly six edges after accept, held until ack 7
    drive(1'b1, 1, M_LEVEL, 5, 0);
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("t2_wait", 32'(irq_timer_o), 32'd0);
    end
    tick();
    check_eq("t2_rise", 32'(irq_timer_o), 32'd1);
    repeat (3) tick();
    check_eq("t2_hold", 32'(irq_timer_o), 32'd1);
    ack(1'b1, 7);
    tick();
    check_eq("t2_fall", 32'(irq_timer_o), 32'd0);
    idle();
    tick();

    // PULSE fast[3], width 4 then width 0
    drive(1'b1, 4 + 3, M_PULSE, 0, 4);
    tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("t3_pulse4_hi", 32'(irq_fast_o[3]), 32'd1);
    end
    tick();
    check_eq("t3_pulse4_lo", 32'(irq_fast_o[3]), 32'd0);
    drive(1'b1, 4 + 3, M_PULSE, 0, 0);
    tick();
    idle();
    tick();
    check_eq("t3_pulse0_hi", 32'(irq_fast_o[3]), 32'd1);
    tick();
    check_eq("t3_pulse0_lo", 32'(irq_fast_o[3]), 32'd0);

    // Second LEVEL on a waiting line is refused; CLEAR is taken
    drive(1'b1, 2, M_LEVEL, 20, 0);
    tick();
    drive(1'b1, 2, M_LEVEL, 0, 0);
    #1;
    check_eq("t4_rdy_busy", 32'(cmd_ready_o), 32'd0);
    tick();
    drive(1'b1, 2, M_CLEAR, 0, 0);
    #1;
    check_eq("t4_rdy_clear", 32'(cmd_ready_o), 32'd1);
    tick();
    idle();
    repeat (25) tick();
    check_eq("t4_ext_low", 32'(irq_external_o), 32'd0);
    check_eq("t4_idle", 32'(busy_o), 32'd0);

    // Out-of-range line is never ready
    drive(1'b1, 25, M_CLEAR, 0, 0);
    #1;
    check_eq("oor_ready", 32'(cmd_ready_o), 32'd0);
    tick();

    // Ack routing between nm and sw
    drive(1'b1, 3, M_LEVEL, 1, 0);
    tick();
    drive(1'b1, 0, M_LEVEL, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    ack(1'b1, 5);
    tick();
    check_eq("t5_ack5", 32'({irq_nm_o, irq_software_o}), 32'd3);
    ack(1'b1, 3);
    tick();
    check_eq("t5_ack3", 32'({irq_nm_o, irq_software_o}), 32'd2);
    ack(1'b1, 31);
    tick();
    check_eq("t5_ack31", 32'({irq_nm_o, irq_software_o}), 32'd0);
    idle();
    tick();

    // Same-cycle CLEAR and matching ack
    drive(1'b1, 1, M_LEVEL, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    drive(1'b1, 1, M_CLEAR, 0, 0);
    ack(1'b1, 7);
    tick();
    check_eq("clr_ack_timer", 32'(irq_timer_o), 32'd0);
    idle();
    tick();

    // Max delay, async reset mid-count
    drive(1'b1, 0, M_PULSE, 65535, 1);
    tick();
    idle();
    repeat (100) tick();
    #3;
    rst_ni = 1'b0;
    #1;
    check_eq("t6_busy_async", 32'(busy_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_eq("t6_sw_after_rst", 32'(irq_software_o), 32'd0);
    drive(1'b1, 0, M_PULSE, 65535, 2);
    #1;
    check_eq("t6_rdy_after_rst", 32'(cmd_ready_o), 32'd1);
    tick();
    idle();
    repeat (65535) tick();
    check_eq("t6_maxd_before", 32'(irq_software_o), 32'd0);
    tick();
    check_eq("t6_maxd_rise", 32'(irq_software_o), 32'd1);
    repeat (2) tick();
    check_eq("t6_maxd_end", 32'(irq_software_o), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 4) begin
        line = (($urandom_range(0, 9) == 0) ? $urandom_range(NL, 31) : $urandom_range(0, NL - 1));
        r = $urandom_range(0, 9);
        drive(1'b1, line, (r < 4) ? M_LEVEL : ((r < 8) ? M_PULSE : M_CLEAR),
              $urandom_range(0, 12), $urandom_range(0, 5));
      end else begin
        drive(1'b0, $urandom_range(0, 31), 2'($urandom_range(0, 2)), 0, 0);
      end
      if ($urandom_range(0, 9) < 4) begin
        ack(1'b1, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31)
                                              : cause_id($urandom_range(0, NL - 1)));
      end else begin
        ack(1'b0, 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
